// File: rtl/preset_time_setter_if.sv
// Interface for the preset time setter: enable, keys, BCD base time in, registered result time out.
// The master side drives keys and base time; the slave side is the setter itself.
interface preset_time_setter_if;
   logic       en;
   logic [9:0] keypad;
   logic       sharp;
   logic [3:0] hour_ten_in, hour_one_in, min_ten_in, min_one_in, sec_ten_in, sec_one_in;
   logic [3:0] hour_ten_out, hour_one_out, min_ten_out, min_one_out, sec_ten_out, sec_one_out;
   logic       completeSetting;
   logic       busy;

   modport master (
      output en, keypad, sharp,
      output hour_ten_in, hour_one_in, min_ten_in, min_one_in, sec_ten_in, sec_one_in,
      input  hour_ten_out, hour_one_out, min_ten_out, min_one_out, sec_ten_out, sec_one_out,
      input  completeSetting, busy
   );

   modport slave (
      input  en, keypad, sharp,
      input  hour_ten_in, hour_one_in, min_ten_in, min_one_in, sec_ten_in, sec_one_in,
      output hour_ten_out, hour_one_out, min_ten_out, min_one_out, sec_ten_out, sec_one_out,
      output completeSetting, busy
   );
endinterface

// File: rtl/preset_time_setter.sv
// Preset shortcut time setter: key presses build a BCD offset, sharp adds it to a snapshot
// of the base time with a digit-serial BCD adder and publishes the result with a pulse.
module preset_time_setter #(
   parameter int                        NUM_PRESETS  = 4,
   parameter logic [24*NUM_PRESETS-1:0] PRESET_TABLE = {24'h001000, 24'h000100, 24'h000030, 24'h000005},
   parameter int                        ACCUMULATE   = 1
) (
   input logic                 clk,
   input logic                 rst,
   preset_time_setter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, SELECT, ACC, ADD} state_e;

   state_e      state_q, state_d;
   logic [9:0]  key_q, key_prev_q;
   logic        sharp_q, sharp_prev_q;
   logic [23:0] offset_q, offset_d;
   logic [23:0] opnd_q, opnd_d;
   logic [19:0] sum_q, sum_d;
   logic [23:0] time_q, time_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        carry_q, carry_d;
   logic        done_q, done_d;

   logic [9:0]  key_edge;
   logic        sharp_edge;
   logic        key_valid;
   logic [23:0] key_preset;
   logic [3:0]  dig_a, dig_b, dig_out;
   logic [4:0]  dig_s, radix;
   logic        carry_out;
   logic [6:0]  hour_s, hour_wrap;
   logic        hour_ovf;

   function automatic logic [7:0] to_bcd(input logic [6:0] h);
      if (h >= 7'd20)      to_bcd = {4'd2, 4'(h - 7'd20)};
      else if (h >= 7'd10) to_bcd = {4'd1, 4'(h - 7'd10)};
      else                 to_bcd = {4'd0, h[3:0]};
   endfunction

   // A selection is valid only when exactly one key rose and it maps to an active preset.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      key_edge   = key_q & ~key_prev_q;
      sharp_edge = sharp_q & ~sharp_prev_q;
      key_valid  = 1'b0;
      key_preset = '0;
      for (int i = 0; i < NUM_PRESETS; i++) begin
         if (key_edge == (10'd1 << i)) begin
            key_valid  = 1'b1;
            key_preset = PRESET_TABLE[24*i +: 24];
         end
      end
   end

   // One BCD digit per cycle; odd digit positions are the tens of seconds/minutes (radix 6).
   always_comb begin
      dig_a     = offset_q[{cnt_q, 2'b00} +: 4];
      dig_b     = opnd_q[{cnt_q, 2'b00} +: 4];
      dig_s     = {1'b0, dig_a} + {1'b0, dig_b} + {4'b0000, carry_q};
      radix     = cnt_q[0] ? 5'd6 : 5'd10;
      carry_out = (dig_s >= radix);
      dig_out   = carry_out ? 4'(dig_s - radix) : dig_s[3:0];
      hour_s    = ({2'b00, dig_s} * 7'd10) + {3'b000, sum_q[19:16]};
      hour_ovf  = (hour_s > 7'd23);
      hour_wrap = hour_ovf ? hour_s - 7'd24 : hour_s;
   end

   always_comb begin
      state_d  = state_q;
      offset_d = offset_q;
      opnd_d   = opnd_q;
      sum_d    = sum_q;
      time_d   = time_q;
      cnt_d    = cnt_q;
      carry_d  = carry_q;
      done_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            offset_d = '0;
            if (bus.en && key_valid) begin
               if (ACCUMULATE != 0) begin
                  opnd_d  = key_preset;
                  cnt_d   = '0;
                  carry_d = 1'b0;
                  state_d = ACC;
               end else begin
                  offset_d = key_preset;
                  state_d  = SELECT;
               end
            end
         end
         SELECT: begin
            if (!bus.en) begin
               offset_d = '0;
               state_d  = IDLE;
            end else if (key_valid) begin
               if (ACCUMULATE != 0) begin
                  opnd_d  = key_preset;
                  cnt_d   = '0;
                  carry_d = 1'b0;
                  state_d = ACC;
               end else begin
                  offset_d = key_preset;
               end
            end else if (sharp_edge) begin
               opnd_d  = {bus.hour_ten_in, bus.hour_one_in, bus.min_ten_in,
                          bus.min_one_in, bus.sec_ten_in, bus.sec_one_in};
               cnt_d   = '0;
               carry_d = 1'b0;
               state_d = ADD;
            end
         end
         ACC, ADD: begin
            if (state_q == ACC && !bus.en) begin
               offset_d = '0;
               cnt_d    = '0;
               carry_d  = 1'b0;
               state_d  = IDLE;
            end else if (cnt_q != 3'd5) begin
               sum_d[{cnt_q, 2'b00} +: 4] = dig_out;
               carry_d = carry_out;
               cnt_d   = cnt_q + 3'd1;
            end else begin
               cnt_d   = '0;
               carry_d = 1'b0;
               if (state_q == ACC) begin
                  offset_d = hour_ovf ? 24'h235959 : {to_bcd(hour_s), sum_q[15:0]};
                  state_d  = SELECT;
               end else begin
                  time_d   = {to_bcd(hour_wrap), sum_q[15:0]};
                  offset_d = '0;
                  done_d   = 1'b1;
                  state_d  = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         key_q        <= '0;
         key_prev_q   <= '0;
         sharp_q      <= 1'b0;
         sharp_prev_q <= 1'b0;
         offset_q     <= '0;
         opnd_q       <= '0;
         sum_q        <= '0;
         time_q       <= '0;
         cnt_q        <= '0;
         carry_q      <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         // NOTE: sequential state uses <= so every flop samples pre-edge values.
         state_q      <= state_d;
         key_q        <= bus.keypad;
         key_prev_q   <= key_q;
         sharp_q      <= bus.sharp;
         sharp_prev_q <= sharp_q;
         offset_q     <= offset_d;
         opnd_q       <= opnd_d;
         sum_q        <= sum_d;
         time_q       <= time_d;
         cnt_q        <= cnt_d;
         carry_q      <= carry_d;
         done_q       <= done_d;
      end
   end

   assign bus.hour_ten_out    = time_q[23:20];
   assign bus.hour_one_out    = time_q[19:16];
   assign bus.min_ten_out     = time_q[15:12];
   assign bus.min_one_out     = time_q[11:8];
   assign bus.sec_ten_out     = time_q[7:4];
   assign bus.sec_one_out     = time_q[3:0];
   assign bus.completeSetting = done_q;
   assign bus.busy            = (state_q == ACC) || (state_q == ADD);

endmodule

// File: tb/tb_preset_time_setter.sv
// Bench for preset_time_setter: three configurations share one stimulus stream; each result
// is queued when sharp is driven and compared when its completion pulse appears.
module tb_preset_time_setter;

   typedef struct packed {
      logic [3:0][9:0]  keys;   // keys[0] pressed first; zero entries skipped
      logic [23:0]      base;
      logic [2:0][23:0] exp;    // exp[j] is the result expected from DUT j
   } txn_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [9:0]  keypad;
   logic        sharp;
   logic [23:0] base;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic        seen_activity;
   logic [23:0] sbq0[$], sbq1[$], sbq2[$];
   logic [23:0] last_exp[3];
   txn_t        vecs[7];

   always #5 clk = ~clk;

   preset_time_setter_if if0 ();
   preset_time_setter_if if1 ();
   preset_time_setter_if if2 ();

   preset_time_setter u0 (.clk(clk), .rst(rst), .bus(if0.slave));
   preset_time_setter #(.ACCUMULATE(0)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
   preset_time_setter #(.PRESET_TABLE({24'h001000, 24'h000100, 24'h000030, 24'h120000}))
      u2 (.clk(clk), .rst(rst), .bus(if2.slave));

   assign if0.en = en;  assign if1.en = en;  assign if2.en = en;
   assign if0.keypad = keypad;  assign if1.keypad = keypad;  assign if2.keypad = keypad;
   assign if0.sharp = sharp;  assign if1.sharp = sharp;  assign if2.sharp = sharp;
   assign {if0.hour_ten_in, if0.hour_one_in, if0.min_ten_in, if0.min_one_in, if0.sec_ten_in, if0.sec_one_in} = base;
   assign {if1.hour_ten_in, if1.hour_one_in, if1.min_ten_in, if1.min_one_in, if1.sec_ten_in, if1.sec_one_in} = base;
   assign {if2.hour_ten_in, if2.hour_one_in, if2.min_ten_in, if2.min_one_in, if2.sec_ten_in, if2.sec_one_in} = base;

   wire [23:0] out0 = {if0.hour_ten_out, if0.hour_one_out, if0.min_ten_out, if0.min_one_out, if0.sec_ten_out, if0.sec_one_out};
   wire [23:0] out1 = {if1.hour_ten_out, if1.hour_one_out, if1.min_ten_out, if1.min_one_out, if1.sec_ten_out, if1.sec_one_out};
   wire [23:0] out2 = {if2.hour_ten_out, if2.hour_one_out, if2.min_ten_out, if2.min_one_out, if2.sec_ten_out, if2.sec_one_out};
   wire [5:0]  stat = {if2.busy, if1.busy, if0.busy, if2.completeSetting, if1.completeSetting, if0.completeSetting};

   function automatic logic [23:0] get_out(input int j);
      case (j)
         0:       get_out = out0;
         1:       get_out = out1;
         default: get_out = out2;
      endcase
   endfunction

   function automatic txn_t mk(input logic [9:0] k0, k1, k2, k3, input logic [23:0] b,
                               input logic [23:0] e0, e1, e2);
      mk.keys = {k3, k2, k1, k0};
      mk.base = b;
      mk.exp  = {e2, e1, e0};
   endfunction

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic press(input logic [9:0] k);
      @(negedge clk) keypad = k;
      @(negedge clk) keypad = '0;
      repeat (10) @(negedge clk);
   endtask

   task automatic watch(input int n);
      repeat (n) begin
         @(negedge clk);
         if (stat != 6'b0) seen_activity = 1'b1;
      end
   endtask

   // Pops the scoreboard entry of each DUT that is pulsing completeSetting and compares it.
   task automatic score(input logic [5:0] s);
      logic [23:0] e;
      for (int j = 0; j < 3; j++) begin
         if (s[j]) begin
            if ((j == 0 && sbq0.size() == 0) || (j == 1 && sbq1.size() == 0) ||
                (j == 2 && sbq2.size() == 0)) begin
               check($sformatf("unexpected_pulse_dut%0d", j), 1, 0);
            end else begin
               case (j)
                  0:       e = sbq0.pop_front();
                  1:       e = sbq1.pop_front();
                  default: e = sbq2.pop_front();
               endcase
               check($sformatf("result_dut%0d", j), {72'b0, get_out(j)}, {72'b0, e});
            end
         end
      end
   endtask

   task automatic run_txn(input int id, input txn_t t);
      logic [5:0] exp_stat;
      for (int i = 0; i < 4; i++) if (t.keys[i] != '0) press(t.keys[i]);
      @(negedge clk);
      base  = t.base;
      sharp = 1'b1;
      sbq0.push_back(t.exp[0]);
      sbq1.push_back(t.exp[1]);
      sbq2.push_back(t.exp[2]);
      // c counts negedges after the edge that captures sharp
      for (int c = 0; c <= 8; c++) begin
         @(negedge clk);
         exp_stat = (c >= 1 && c <= 6) ? 6'b111_000 : (c == 7) ? 6'b000_111 : 6'b000_000;
         check($sformatf("txn%0d_status_c%0d", id, c), {90'b0, stat}, {90'b0, exp_stat});
         score(stat);
         if (c == 0) check($sformatf("txn%0d_hold", id), {24'b0, out2, out1, out0},
                           {24'b0, last_exp[2], last_exp[1], last_exp[0]});
         if (c == 0) sharp = 1'b0;
         if (c == 1) base = 24'h111111;
         if (c == 2) begin keypad = 10'h001; sharp = 1'b1; end
         if (c == 3) begin keypad = '0; sharp = 1'b0; end
      end
      check($sformatf("txn%0d_sb_drained", id), sbq0.size() + sbq1.size() + sbq2.size(), 0);
      for (int j = 0; j < 3; j++) last_exp[j] = t.exp[j];
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vecs[0] = mk(10'h001, 10'h000, 10'h000, 10'h000, 24'h123456, 24'h123501, 24'h123501, 24'h003456);
      vecs[1] = mk(10'h004, 10'h000, 10'h000, 10'h000, 24'h235958, 24'h000058, 24'h000058, 24'h000058);
      vecs[2] = mk(10'h002, 10'h002, 10'h001, 10'h000, 24'h000000, 24'h000105, 24'h000005, 24'h120100);
      vecs[3] = mk(10'h001, 10'h001, 10'h000, 10'h000, 24'h000001, 24'h000011, 24'h000006, 24'h000000);
      vecs[4] = mk(10'h008, 10'h000, 10'h000, 10'h000, 24'h095959, 24'h100959, 24'h100959, 24'h100959);
      vecs[5] = mk(10'h008, 10'h004, 10'h000, 10'h000, 24'h154530, 24'h155630, 24'h154630, 24'h155630);
      vecs[6] = mk(10'h008, 10'h008, 10'h008, 10'h008, 24'h233000, 24'h001000, 24'h234000, 24'h001000);
      for (int j = 0; j < 3; j++) last_exp[j] = '0;

      rst = 1'b1; en = 1'b1; keypad = '0; sharp = 1'b0; base = '0;
      repeat (3) @(negedge clk);
      check("reset_state", {18'b0, out2, out1, out0, stat}, 96'b0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      for (int v = 0; v < 7; v++) run_txn(v, vecs[v]);

      // Out-of-range key, two simultaneous keys, and sharp with nothing selected: all ignored.
      seen_activity = 1'b0;
      @(negedge clk) keypad = 10'h080;
      @(negedge clk) keypad = '0;
      watch(4);
      keypad = 10'h003;
      @(negedge clk) keypad = '0;
      watch(4);
      sharp = 1'b1;
      @(negedge clk) sharp = 1'b0;
      watch(12);
      check("ignored_events_activity", {95'b0, seen_activity}, 96'b0);
      check("ignored_events_outputs", {24'b0, out2, out1, out0},
            {24'b0, last_exp[2], last_exp[1], last_exp[0]});

      // Enable dropped in SELECT discards the selection; a later sharp does nothing.
      press(10'h001);
      en = 1'b0;
      repeat (2) @(negedge clk);
      en = 1'b1;
      seen_activity = 1'b0;
      sharp = 1'b1;
      @(negedge clk) sharp = 1'b0;
      watch(12);
      check("en_drop_activity", {95'b0, seen_activity}, 96'b0);
      check("en_drop_outputs_held", {24'b0, out2, out1, out0},
            {24'b0, last_exp[2], last_exp[1], last_exp[0]});

      // Reset during the fourth ADD cycle: no pulse, outputs cleared, back to IDLE.
      press(10'h001);
      @(negedge clk);
      base  = 24'h010203;
      sharp = 1'b1;
      for (int c = 0; c <= 3; c++) begin
         @(negedge clk);
         if (c == 0) sharp = 1'b0;
      end
      check("mid_add_busy_before_reset", {93'b0, stat[5:3]}, {93'b0, 3'b111});
      rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      seen_activity = 1'b0;
      watch(12);
      check("mid_add_reset_no_pulse", {95'b0, seen_activity}, 96'b0);
      check("mid_add_reset_outputs", {24'b0, out2, out1, out0}, 96'b0);
      for (int j = 0; j < 3; j++) last_exp[j] = '0;

      // Recovery after reset, with a fresh offset.
      run_txn(7, vecs[0]);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/preset_time_setter.md
PRESET_TIME_SETTER -- requirements
Module: preset_time_setter

Interface
REQ-001 The block SHALL have parameter NUM_PRESETS, default 4: number of active shortcut keys (legal range 1..10; keypad[i] maps to preset i).
REQ-002 The block SHALL have parameter PRESET_TABLE, width 24*NUM_PRESETS, default {24'h001000, 24'h000100, 24'h000030, 24'h000005}: packed BCD HHMMSS per preset, with preset 0 in bits [23:0].
REQ-003 The block SHALL have parameter ACCUMULATE, default 1: 1 means each key press adds to the pending offset; 0 means the latest press replaces it.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port en, input, 1 bit: block enable.
REQ-007 The block SHALL have port keypad, input, 10 bits: level-high key lines.
REQ-008 The block SHALL have port sharp, input, 1 bit: confirm key, level-high.
REQ-009 The block SHALL have ports hour_ten_in, hour_one_in, min_ten_in, min_one_in, sec_ten_in, sec_one_in, input, 4 bits each: base time in BCD.
REQ-010 The block SHALL have ports hour_ten_out, hour_one_out, min_ten_out, min_one_out, sec_ten_out, sec_one_out, output, 4 bits each: result time in BCD, registered.
REQ-011 The block SHALL have port completeSetting, output, 1 bit: one-cycle pulse when the result is valid.
REQ-012 The block SHALL have port busy, output, 1 bit: high while in the ACC or ADD state.

Function
REQ-013 The block SHALL register keypad and sharp each cycle and act only on rising edges (input high now and low in the previous cycle).
REQ-014 A keypad edge SHALL be a valid selection only if exactly one keypad bit has an edge and its index is less than NUM_PRESETS; all other edge patterns SHALL be ignored.
REQ-015 The FSM SHALL have exactly four states: IDLE, SELECT, ACC, ADD. The completion pulse SHALL be issued on the transition out of ADD.
REQ-016 IDLE: pending offset SHALL equal 0; a valid selection while en=1 SHALL load the offset and move to SELECT.
REQ-017 The IDLE load SHALL behave as follows for both ACCUMULATE settings:
- load = preset when ACCUMULATE=0;
- load = 0 + preset via ACC when ACCUMULATE=1.
REQ-018 SELECT: a valid selection SHALL behave as follows:
- ACCUMULATE=0: replace the offset in one cycle;
- ACCUMULATE=1: enter ACC.
REQ-019 SELECT: a sharp edge SHALL snapshot the six base-time inputs and enter ADD.
REQ-020 ACC and ADD SHALL each use a digit-serial BCD adder with this schedule:
- one digit per cycle, order sec_one, sec_ten, min_one, min_ten, hour_one, hour_ten;
- 6 cycles total;
- the carry SHALL be held in a register between digits.
REQ-021 The digit radix SHALL be 10 for sec_one, 6 for sec_ten, 10 for min_one and 6 for min_ten; hours SHALL be resolved as a two-digit value after the hour_ten step.
REQ-022 ACC SHALL add the preset to the pending offset and saturate the result at 23:59:59 if the hour sum exceeds 23, then return to SELECT.
REQ-023 ADD SHALL compute the result as (snapshot + offset) modulo 24 h, with hours wrapping 24 to 00 and seconds and minutes carrying into the next digit.
REQ-024 Latency: if the sharp edge is detected at edge k, then:
- ADD SHALL occupy cycles k+1..k+6;
- the outputs SHALL update at edge k+7;
- completeSetting SHALL be high for exactly the cycle after edge k+7;
- the FSM SHALL return to IDLE at edge k+7.
REQ-025 The outputs SHALL hold the last result until the next completion or reset; they SHALL NOT track the base inputs.
REQ-026 A sharp edge in IDLE (no selection made) SHALL be ignored; no pulse SHALL be issued.
REQ-027 Key and sharp edges during ACC or ADD SHALL be ignored, and the snapshot SHALL remain frozen.
REQ-028 A simultaneous valid key edge and sharp edge in SELECT SHALL be resolved in favour of the key; the sharp edge SHALL be discarded.
REQ-029 If en=0 in SELECT or ACC, the block SHALL discard the offset and go to IDLE next cycle; ADD SHALL complete regardless of en.
REQ-030 Non-BCD base inputs SHALL be out of contract; the result for them is undefined but the FSM SHALL still return to IDLE.

Reset
REQ-031 When rst=1 at a clock edge, the block SHALL enter this state:
- state IDLE;
- offset, snapshot, carry and digit counter 0;
- all time outputs 4'h0;
- completeSetting 0 and busy 0;
- edge-detect registers 0.
REQ-032 Reset SHALL take priority over all events, including mid-ACC and mid-ADD; the interrupted operation SHALL produce no pulse.

Verification
REQ-033 Bench SHALL cover: base 12:34:56, keypad[0] edge, sharp edge at k -> outputs 12:35:01 at k+7, completeSetting one cycle, busy high k+1..k+6.
REQ-034 Bench SHALL cover: base 23:59:58, keypad[2], sharp -> 00:00:58 (24 h wrap).
REQ-035 Bench SHALL cover: ACCUMULATE=1, keypad[1], keypad[1], keypad[0], base 00:00:00, sharp -> 00:01:05; with ACCUMULATE=0 the same sequence -> 00:00:05.
REQ-036 Bench SHALL cover: PRESET_TABLE preset0=12:00:00, keypad[0] pressed twice -> offset saturates at 23:59:59; base 00:00:01 -> 00:00:00.
REQ-037 Bench SHALL cover: NUM_PRESETS=4, keypad[7] edge, keypad 0x003 edge, sharp in IDLE -> no state change, no pulse; rst at cycle k+3 of ADD -> outputs 0, no pulse, IDLE.
REQ-038 Bench SHALL cover: en dropped in SELECT, then sharp -> no pulse; prior outputs held unchanged.
